// File: rtl/word_serializer_16bit.sv
// Framed LSB-first serializer for a 16-bit word: start, 16 data bits, optional parity, stop.
// A valid/ready handshake loads the word, and every output is driven straight from a flop.
module word_serializer_16bit #(
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] d,
    output logic        tx,
    output logic        bit_strobe,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [7:0] LAST_CYC = 8'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cyc_q, cyc_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] shift_q, shift_d;
    logic        par_q, par_d;
    logic        tx_q, tx_d;
    logic        strobe_q, strobe_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        last_cyc;

    assign last_cyc = (cyc_q == LAST_CYC);

    // NOTE: every variable gets a default at the top of the block, so no path can leave a latch.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;

        unique case (state_q)
            IDLE: begin
                if (load_valid) begin
                    shift_d = d;
                    par_d   = (^d) ^ PARITY_ODD;
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (last_cyc) state_d = DATA;
            end
            DATA: begin
                if (last_cyc) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'd15) state_d = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (last_cyc) state_d = STOP;
            end
            STOP: begin
                if (last_cyc) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) cyc_d = last_cyc ? 8'd0 : cyc_q + 8'd1;
    end

    // Output flops load the values that belong to the next state, so each output lines up with that state.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
        strobe_d = (state_d != IDLE) && (cyc_d == 8'd0);
        busy_d   = (state_d != IDLE);
        ready_d  = (state_d == IDLE);
        done_d   = (state_q == STOP) && (state_d == IDLE);
    end

    // NOTE: state flops use non-blocking assignments only. The small shift register is plain flops, not a RAM, so it is reset as well.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cyc_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign tx         = tx_q;
    assign bit_strobe = strobe_q;
    assign busy       = busy_q;
    assign load_ready = ready_q;
    assign done       = done_q;

endmodule

// File: tb/tb_word_serializer_16bit.sv
// Self-checking bench for word_serializer_16bit: three parameterisations, compared cycle by cycle
// against a frame model built from the word's bit list.
module tb_word_serializer_16bit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] d;
    logic [2:0]  lv;
    logic [2:0]  lr_w, tx_w, bs_w, busy_w, done_w;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    word_serializer_16bit #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even4 (
        .clk(clk), .reset(reset), .load_valid(lv[0]), .load_ready(lr_w[0]), .d(d),
        .tx(tx_w[0]), .bit_strobe(bs_w[0]), .busy(busy_w[0]), .done(done_w[0]));

    word_serializer_16bit #(.CLKS_PER_BIT(2), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd2 (
        .clk(clk), .reset(reset), .load_valid(lv[1]), .load_ready(lr_w[1]), .d(d),
        .tx(tx_w[1]), .bit_strobe(bs_w[1]), .busy(busy_w[1]), .done(done_w[1]));

    word_serializer_16bit #(.CLKS_PER_BIT(1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_nopar1 (
        .clk(clk), .reset(reset), .load_valid(lv[2]), .load_ready(lr_w[2]), .d(d),
        .tx(tx_w[2]), .bit_strobe(bs_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    function automatic int cpb_of(int i);
        case (i)
            0:       return 4;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int pen_of(int i);
        return (i == 2) ? 0 : 1;
    endfunction

    function automatic int podd_of(int i);
        return (i == 1) ? 1 : 0;
    endfunction

    // Frame cycle c (1-based) belongs to bit slot (c-1)/cpb: slot 0 is start, slots 1..16 are data, then parity, then stop.
    function automatic logic exp_tx(int i, logic [15:0] w, int c);
        int b;
        b = (c - 1) / cpb_of(i);
        if (b == 0) return 1'b0;
        if (b <= 16) return w[b-1];
        if (pen_of(i) == 1 && b == 17) return ((($countones(w) + podd_of(i)) % 2) == 1);
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input int i, input logic [15:0] w);
        check($sformatf("i%0d_ready_before_offer", i), 32'(lr_w[i]), 32'd1);
        d     = w;
        lv[i] = 1'b1;
    endtask

    // Called at the negedge before the acceptance edge. Returns at the negedge of the done cycle.
    task automatic run_frame(input int i, input logic [15:0] w, input bit keep, input logic [15:0] new_d);
        int n;
        int strobes;
        n       = (18 + pen_of(i)) * cpb_of(i);
        strobes = 0;
        @(posedge clk);
        @(negedge clk);
        if (!keep) lv[i] = 1'b0;
        for (int c = 1; c <= n; c++) begin
            check($sformatf("i%0d_w%04h_tx_c%0d", i, w, c), 32'(tx_w[i]), 32'(exp_tx(i, w, c)));
            check($sformatf("i%0d_w%04h_strobe_c%0d", i, w, c), 32'(bs_w[i]), 32'(((c - 1) % cpb_of(i)) == 0));
            check($sformatf("i%0d_busy_c%0d", i, c), 32'(busy_w[i]), 32'd1);
            check($sformatf("i%0d_ready_c%0d", i, c), 32'(lr_w[i]), 32'd0);
            check($sformatf("i%0d_done_c%0d", i, c), 32'(done_w[i]), 32'd0);
            if (bs_w[i]) strobes++;
            if (keep && c == n / 2) d = new_d;
            @(negedge clk);
        end
        check($sformatf("i%0d_w%04h_strobe_count", i, w), 32'(strobes), 32'(18 + pen_of(i)));
        check($sformatf("i%0d_w%04h_done", i, w), 32'(done_w[i]), 32'd1);
        check($sformatf("i%0d_w%04h_busy_after", i, w), 32'(busy_w[i]), 32'd0);
        check($sformatf("i%0d_w%04h_ready_after", i, w), 32'(lr_w[i]), 32'd1);
        check($sformatf("i%0d_w%04h_tx_gap", i, w), 32'(tx_w[i]), 32'd1);
    endtask

    initial begin
        logic [15:0] w;
        int          i;

        reset = 1'b0;
        lv    = '0;
        d     = '0;
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("i%0d_reset_tx", k), 32'(tx_w[k]), 32'd1);
            check($sformatf("i%0d_reset_ready", k), 32'(lr_w[k]), 32'd1);
            check($sformatf("i%0d_reset_busy", k), 32'(busy_w[k]), 32'd0);
            check($sformatf("i%0d_reset_done", k), 32'(done_w[k]), 32'd0);
            check($sformatf("i%0d_reset_strobe", k), 32'(bs_w[k]), 32'd0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Basic frame with even parity, then the two parity-mode corner words.
        offer(0, 16'hA5C3);
        run_frame(0, 16'hA5C3, 1'b0, 16'h0000);
        offer(0, 16'h0001);
        run_frame(0, 16'h0001, 1'b0, 16'h0000);
        offer(1, 16'h0000);
        run_frame(1, 16'h0000, 1'b0, 16'h0000);
        w = 16'($urandom);
        offer(2, w);
        run_frame(2, w, 1'b0, 16'h0000);

        // load_valid held high while d changes mid-frame. The new word is taken in the done cycle and sent back-to-back.
        offer(0, 16'h3C5A);
        run_frame(0, 16'h3C5A, 1'b1, 16'hFFFF);
        run_frame(0, 16'hFFFF, 1'b0, 16'h0000);

        for (int r = 0; r < 6; r++) begin
            i = int'($urandom_range(0, 2));
            w = 16'($urandom);
            offer(i, w);
            run_frame(i, w, 1'b0, 16'h0000);
        end

        // Abort during data bit 7 of an all-zero word, so the line must visibly return high.
        offer(0, 16'h0000);
        @(posedge clk);
        #1 lv[0] = 1'b0;
        repeat (33) @(posedge clk);
        #1;
        check("abort_tx_before_reset", 32'(tx_w[0]), 32'(exp_tx(0, 16'h0000, 34)));
        check("abort_busy_before_reset", 32'(busy_w[0]), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_tx", 32'(tx_w[0]), 32'd1);
        check("abort_ready", 32'(lr_w[0]), 32'd1);
        check("abort_busy", 32'(busy_w[0]), 32'd0);
        check("abort_done", 32'(done_w[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            check($sformatf("abort_no_done_c%0d", c), 32'(done_w[0]), 32'd0);
        end
        offer(0, 16'h1234);
        run_frame(0, 16'h1234, 1'b0, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/word_serializer_16bit.md
# word_serializer_16bit

Read side of the 16-bit register datapath. The block takes a parallel word from a `register_16bit` `Q` output through a valid/ready load handshake and shifts it out LSB-first on a single framed serial line. Each frame is one start bit, 16 data bits, an optional parity bit and one stop bit. It sits between the lab's register/arithmetic datapath and an off-chip observer, for example a pin or a logic analyser.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; legal range 1..255.
- `PARITY_EN`, default 1: 1 inserts a parity bit after data bit 15; 0 omits it.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity. Ignored when `PARITY_EN`=0.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high; forces every output to its reset value immediately.
- `load_valid` input 1: a word is offered on `d`.
- `load_ready` output 1: the block can accept a word; high exactly when the state is IDLE.
- `d` input 16: parallel word, normally wired to a `register_16bit` `Q`.
- `tx` output 1: serial line; idles high.
- `bit_strobe` output 1: one-cycle pulse in the first cycle of every transmitted bit (start, data, parity, stop).
- `busy` output 1: high from the first start-bit cycle through the last stop-bit cycle.
- `done` output 1: one-cycle pulse after the stop bit completes.

## Operation
- Reset values:
  - `tx`=1, `load_ready`=1, `busy`=0, `bit_strobe`=0, `done`=0.
  - Shift register, bit counter and cycle counter are all 0.
  - State is IDLE.
- FSM states are IDLE, START, DATA, PARITY and STOP. All outputs are registered.
- IDLE:
  - `tx`=1.
  - On an edge where `load_valid`=1 and `load_ready`=1, capture `d` into the shift register and compute the parity bit.
    - Parity bit = XOR of the 16 captured bits, inverted when `PARITY_ODD`=1.
  - Go to START.
  - `load_valid` has no effect outside IDLE. `d` is sampled only at acceptance; later changes on `d` do not affect the frame.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA:
  - `tx` = shift register bit 0.
  - After each `CLKS_PER_BIT` cycles, shift right and increment the bit counter.
  - After bit 15, go to PARITY if `PARITY_EN`=1, otherwise to STOP.
- PARITY: `tx` = parity bit for `CLKS_PER_BIT` cycles, then go to STOP.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE and pulse `done` in the first IDLE cycle.
- Cycle counter:
  - Counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on each bit boundary.
  - `bit_strobe`=1 when the counter is 0 in START/DATA/PARITY/STOP.
- Back-to-back frames:
  - A word may be accepted in the same cycle `done` is high.
  - Between frames the line therefore stays high for exactly 1 cycle, in addition to the stop bit.
- Reset mid-frame aborts the frame:
  - `tx` returns high asynchronously.
  - No `done` pulse is produced.
  - The captured word is discarded.

## Timing
- Acceptance edge k:
  - `tx` falls, `busy` rises and `bit_strobe` pulses in cycle k+1.
  - `load_ready` falls in cycle k+1.
- Frame length N = (18 + `PARITY_EN`) × `CLKS_PER_BIT` cycles.
  - The frame occupies cycles k+1 .. k+N.
  - `busy`=0, `done`=1 and `load_ready`=1 in cycle k+N+1.
- Data bit i (0..15) occupies cycles k+1+(1+i)·`CLKS_PER_BIT` onward, each lasting `CLKS_PER_BIT` cycles.
- With `CLKS_PER_BIT`=1, `bit_strobe` is high for every cycle of the frame.
- Throughput limit: one word per N+1 cycles.

## Test plan
- Reset:
  - Assert `reset` asynchronously between edges.
  - Required: `tx`=1, `load_ready`=1, `busy`=0 and `done`=0 immediately, before the next edge.
- Basic frame:
  - Setup: `CLKS_PER_BIT`=4, even parity, `d`=16'hA5C3.
  - Required frame: start 0; data 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; parity 0; stop 1.
  - Required timing: 76 cycles from acceptance, `done` pulses in cycle 77, 19 `bit_strobe` pulses.
- Parity modes:
  - `d`=16'h0001 with even parity: parity bit 1.
  - `d`=16'h0000 with `PARITY_ODD`=1: parity bit 1.
  - `PARITY_EN`=0 with `CLKS_PER_BIT`=1: 18-cycle frame with no parity bit.
- Load protocol:
  - Hold `load_valid`=1 and change `d` to 16'hFFFF mid-frame.
  - Required: the frame still carries the original word; no second acceptance until the `done` cycle.
  - Required: the next frame starts in the cycle after `done`, with 1 idle-high cycle between frames.
- Reset mid-frame:
  - Assert `reset` during data bit 7, release it, then offer 16'h1234.
  - Required: no `done` pulse for the aborted word.
  - Required: a clean full frame of 16'h1234 follows.
